pb_bus_reader: RTL and testbench
================================

Name: pb_bus_reader

Overview:
- Executes one read cycle on the 8-bit lamp-board parallel bus: drives the address, strobes Rd, and samples the data port.
- Returns the sampled byte on a result port and also pushes it into the UART TX FIFO as a response line.
- It is the read counterpart of the existing pb write path, driven by the command parser after it decodes a "pb_i_read," command.
- The top level muxes its bus outputs with the write path; the parser guarantees only one path is active at a time.

Parameters:
- SETUP_CYCLES, 4: clocks the address is held stable before Rd rises. Minimum 1.
- STROBE_CYCLES, 8: clocks Rd is held high. Minimum 1.
- HOLD_CYCLES, 4: clocks the address is held after Rd falls. Minimum 1.
- CNT_W, 8: width of the phase counter. Must satisfy 2^CNT_W > max(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES).

Ports:
- clock, in, 1: system clock, 27 MHz.
- reset_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: read request.
- req_ready, out, 1: high only in IDLE. A request is accepted when req_valid and req_ready are both high on a clock edge.
- req_addr, in, 3: bus address to read.
- req_test_addr, in, 1: value to drive on the TestAddress line for this cycle.
- busy, out, 1: equal to not req_ready.
- pb_addr, out, 3: address port drive.
- pb_test_addr, out, 1: TestAddress drive.
- pb_rd, out, 1: read strobe, active high.
- pb_data_in, in, 8: data port from the level shifter.
- rd_data, out, 8: last sampled byte.
- rd_data_valid, out, 1: one-cycle pulse when rd_data updates.
- tx_fifo_data_in, out, 8: byte to the UART TX FIFO.
- tx_fifo_write_en, out, 1: one-cycle write pulse.
- tx_fifo_full, in, 1: TX FIFO full flag.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, pb_addr=0, pb_test_addr=1, pb_rd=0, rd_data=0, rd_data_valid=0, tx_fifo_data_in=0, tx_fifo_write_en=0, all counters 0.
- Reset mid-operation: the cycle is abandoned, Rd drops at once, no FIFO write occurs, and nothing is resumed after reset.
- States: IDLE -> SETUP -> STROBE -> HOLD -> EMIT -> GAP -> EMIT ... -> IDLE.
- IDLE: on accept, register req_addr and req_test_addr onto pb_addr and pb_test_addr (visible the next cycle), clear the counter, go to SETUP.
- SETUP: pb_rd=0. Count SETUP_CYCLES clocks, then go to STROBE.
- STROBE: pb_rd=1 for exactly STROBE_CYCLES clocks. On the last STROBE clock, capture rd_data <= pb_data_in, then go to HOLD.
- HOLD entry: rd_data_valid pulses on the first HOLD cycle. pb_rd=0; pb_addr and pb_test_addr stay unchanged for HOLD_CYCLES clocks.
- Leaving HOLD: pb_test_addr returns to 1, pb_addr to 0, and the state goes to EMIT with char index 0.
- Latency from accept to rd_data_valid: 1 + SETUP_CYCLES + STROBE_CYCLES clocks.
- EMIT: if tx_fifo_full=0, drive tx_fifo_data_in = char[index], pulse tx_fifo_write_en for one cycle, increment index, go to GAP. If tx_fifo_full=1, stall in EMIT with write_en=0; there is no timeout.
- GAP: write_en=0 for one cycle. Return to EMIT if index < line length, else go to IDLE.
- Back-to-back writes are never issued; at least one idle cycle separates FIFO writes.
- Response line (hex mode): upper nibble ASCII, lower nibble ASCII, 0x0D, 0x0A.
- Nibble encoding: values 0-9 map to 0x30+n; values 10-15 map to 0x41+n-10 (upper case).
- req_valid high while busy is ignored; the request is not queued.
- req_ready rises the cycle after the final GAP.

Optional Feature:
- Macro PB_READ_HEX_EN.
- Defined: the 4-byte ASCII hex line above is emitted.
- Undefined: a single raw byte equal to rd_data is emitted (line length 1). The nibble-conversion logic is removed. Bus timing is unchanged.

Test Plan:
- Read, hex mode, defaults: pb_data_in=0xA5, req_addr=3 -> pb_addr=3 for cycles 1..16 after accept; pb_rd high for exactly 8 clocks; rd_data=0xA5 with rd_data_valid on cycle 13; FIFO receives 0x41,0x35,0x0D,0x0A with one idle cycle between writes.
- Digit boundaries: data 0x09 -> "09\r\n"; data 0xF0 -> "F0\r\n".
- Backpressure: hold tx_fifo_full=1 for 20 clocks at the first EMIT -> no write_en during the stall; the same 4 bytes follow after release; busy stays high throughout.
- Request while busy: pulse req_valid with addr 5 during STROBE -> ignored; pb_addr is unchanged; exactly one response line is emitted.
- Reset mid-strobe: assert reset_n=0 on STROBE cycle 4 -> pb_rd=0 immediately; no FIFO write; after release req_ready=1, and a fresh read completes normally.
- PB_READ_HEX_EN undefined: data 0x3C -> a single FIFO write of 0x3C, then IDLE.

Source files
------------

// File: rtl/pb_bus_reader_if.sv
// pb_bus_reader_if: request handshake, parallel-bus pins and TX FIFO push port of the pb read path.
interface pb_bus_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_addr;
    logic       req_test_addr;
    logic       busy;
    logic [2:0] pb_addr;
    logic       pb_test_addr;
    logic       pb_rd;
    logic [7:0] pb_data_in;
    logic [7:0] rd_data;
    logic       rd_data_valid;
    logic [7:0] tx_fifo_data_in;
    logic       tx_fifo_write_en;
    logic       tx_fifo_full;
    modport slave (
        input  req_valid, req_addr, req_test_addr, pb_data_in, tx_fifo_full,
        output req_ready, busy, pb_addr, pb_test_addr, pb_rd, rd_data, rd_data_valid,
               tx_fifo_data_in, tx_fifo_write_en
    );
    modport master (
        output req_valid, req_addr, req_test_addr, pb_data_in, tx_fifo_full,
        input  req_ready, busy, pb_addr, pb_test_addr, pb_rd, rd_data, rd_data_valid,
               tx_fifo_data_in, tx_fifo_write_en
    );
endinterface

// File: rtl/pb_bus_reader.sv
// pb_bus_reader: one read cycle on the lamp-board bus, result pushed to the UART TX FIFO.
// Define PB_READ_HEX_EN to emit an ASCII hex line "HL\r\n" instead of the raw byte.
module pb_bus_reader #(
    parameter int SETUP_CYCLES  = 4,
    parameter int STROBE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 4,
    parameter int CNT_W         = 8
) (
    input logic            clock,
    input logic            reset_n,
    pb_bus_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, EMIT, GAP} state_t;
`ifdef PB_READ_HEX_EN
    localparam logic [2:0] LINE_LEN = 3'd4;
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
`else
    localparam logic [2:0] LINE_LEN = 3'd1;
`endif
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [2:0]       addr_n;
    logic             test_addr_n, rd_n, valid_n, wr_n, last;
    logic [7:0]       data_n, tx_data_n, line_char;
    assign last = cnt == CNT_W'(state == SETUP ? SETUP_CYCLES - 1 :
                                state == STROBE ? STROBE_CYCLES - 1 : HOLD_CYCLES - 1);
`ifdef PB_READ_HEX_EN
    assign line_char = idx == 3'd0 ? hex_char(bus.rd_data[7:4]) :
                       idx == 3'd1 ? hex_char(bus.rd_data[3:0]) :
                       idx == 3'd2 ? 8'h0D : 8'h0A;
`else
    assign line_char = bus.rd_data;
`endif
    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    always_comb begin
        state_n     = state;
        cnt_n       = '0;
        idx_n       = idx;
        addr_n      = bus.pb_addr;
        test_addr_n = bus.pb_test_addr;
        rd_n        = 1'b0;
        data_n      = bus.rd_data;
        valid_n     = 1'b0;
        tx_data_n   = bus.tx_fifo_data_in;
        wr_n        = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_n     = SETUP;
                addr_n      = bus.req_addr;
                test_addr_n = bus.req_test_addr;
            end
            SETUP: begin
                cnt_n   = last ? '0 : cnt + 1'b1;
                rd_n    = last;
                state_n = last ? STROBE : SETUP;
            end
            STROBE: begin
                cnt_n   = last ? '0 : cnt + 1'b1;
                rd_n    = !last;
                state_n = last ? HOLD : STROBE;
                data_n  = last ? bus.pb_data_in : bus.rd_data;
                valid_n = last;
            end
            HOLD: begin
                cnt_n = last ? '0 : cnt + 1'b1;
                if (last) begin
                    state_n     = EMIT;
                    idx_n       = '0;
                    addr_n      = '0;
                    test_addr_n = 1'b1;
                end
            end
            EMIT: if (!bus.tx_fifo_full) begin
                wr_n      = 1'b1;
                tx_data_n = line_char;
                idx_n     = idx + 1'b1;
                state_n   = GAP;
            end
            GAP:     state_n = idx < LINE_LEN ? EMIT : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            cnt                  <= '0;
            idx                  <= '0;
            bus.pb_addr          <= '0;
            bus.pb_test_addr     <= 1'b1;
            bus.pb_rd            <= 1'b0;
            bus.rd_data          <= '0;
            bus.rd_data_valid    <= 1'b0;
            bus.tx_fifo_data_in  <= '0;
            bus.tx_fifo_write_en <= 1'b0;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            idx                  <= idx_n;
            bus.pb_addr          <= addr_n;
            bus.pb_test_addr     <= test_addr_n;
            bus.pb_rd            <= rd_n;
            bus.rd_data          <= data_n;
            bus.rd_data_valid    <= valid_n;
            bus.tx_fifo_data_in  <= tx_data_n;
            bus.tx_fifo_write_en <= wr_n;
        end
    end
endmodule

// File: tb/tb_pb_bus_reader.sv
// tb_pb_bus_reader: directed bench for pb_bus_reader; expected FIFO line follows PB_READ_HEX_EN.
module tb_pb_bus_reader;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    pb_bus_reader_if bus();
    pb_bus_reader dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    int checks = 0;
    int failures = 0;
    int b2b = 0;
    logic prev_wr = 1'b0;
    logic [7:0] rx[$];
`ifdef PB_READ_HEX_EN
    localparam int LEN = 4;
`else
    localparam int LEN = 1;
`endif
    always @(negedge clock) begin
        if (bus.tx_fifo_write_en) rx.push_back(bus.tx_fifo_data_in);
        if (bus.tx_fifo_write_en && prev_wr) b2b++;
        prev_wr = bus.tx_fifo_write_en;
    end
    task automatic issue(input logic [2:0] addr, input logic ta);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr = addr;
        bus.req_test_addr = ta;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask
    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 300 && to; i++) begin
            @(negedge clock);
            if (bus.req_ready) to = 1'b0;
        end
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.pb_addr !== 3'd0) begin failures++; $display("FAIL reset_addr got %0h want 0", bus.pb_addr); end
        checks++; if (bus.pb_test_addr !== 1'b1) begin failures++; $display("FAIL reset_test_addr got %b want 1", bus.pb_test_addr); end
        checks++; if (bus.pb_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got %b want 0", bus.pb_rd); end
        checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); end
        checks++; if (bus.rd_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.rd_data_valid); end
        checks++; if (bus.tx_fifo_write_en !== 1'b0 || bus.tx_fifo_data_in !== 8'h00) begin
            failures++; $display("FAIL reset_fifo got wr=%b data=%0h want wr=0 data=0", bus.tx_fifo_write_en, bus.tx_fifo_data_in);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask
    task automatic test_read();
        int rd_cnt = 0, rd_bad = 0, addr_bad = 0, val_cnt = 0, val_at = 0;
        logic [7:0] data_at = 8'h00;
        logic [7:0] exp[4];
        bit to;
`ifdef PB_READ_HEX_EN
        exp = '{8'h41, 8'h35, 8'h0D, 8'h0A};
`else
        exp = '{8'hA5, 8'h00, 8'h00, 8'h00};
`endif
        bus.pb_data_in = 8'hA5;
        rx.delete();
        b2b = 0;
        issue(3'd3, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clock);
            if (bus.pb_rd) rd_cnt++;
            if (bus.pb_rd !== logic'(c >= 5 && c <= 12)) rd_bad++;
            if (c <= 16 ? (bus.pb_addr !== 3'd3 || bus.pb_test_addr !== 1'b0)
                        : (bus.pb_addr !== 3'd0 || bus.pb_test_addr !== 1'b1)) addr_bad++;
            if (bus.rd_data_valid) begin val_cnt++; val_at = c; data_at = bus.rd_data; end
        end
        checks++; if (rd_cnt != 8) begin failures++; $display("FAIL read_rd_len got %0d want 8", rd_cnt); end
        checks++; if (rd_bad != 0) begin failures++; $display("FAIL read_rd_window got %0d bad cycles want 0", rd_bad); end
        checks++; if (addr_bad != 0) begin failures++; $display("FAIL read_addr_hold got %0d bad cycles want 0", addr_bad); end
        checks++; if (val_cnt != 1 || val_at != 13) begin failures++; $display("FAIL read_valid got %0d pulses at %0d want 1 at 13", val_cnt, val_at); end
        checks++; if (data_at !== 8'hA5) begin failures++; $display("FAIL read_rd_data got %0h want a5", data_at); end
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL read_idle got timeout want idle"); end
        checks++; if (rx.size() != LEN) begin failures++; $display("FAIL read_len got %0d want %0d", rx.size(), LEN); end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp[i]) begin
                failures++; $display("FAIL read_byte%0d got %0h want %0h", i, i < rx.size() ? rx[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (b2b != 0) begin failures++; $display("FAIL read_b2b got %0d want 0", b2b); end
    endtask
    task automatic test_line(input string name, input logic [7:0] data, input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] exp[4];
        bit to;
`ifdef PB_READ_HEX_EN
        exp = '{hi, lo, 8'h0D, 8'h0A};
`else
        exp = '{data, 8'h00, 8'h00, 8'h00};
`endif
        bus.pb_data_in = data;
        rx.delete();
        b2b = 0;
        issue(3'd4, 1'b1);
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL %s_idle got timeout want idle", name); end
        checks++; if (rx.size() != LEN) begin failures++; $display("FAIL %s_len got %0d want %0d", name, rx.size(), LEN); end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp[i]) begin
                failures++; $display("FAIL %s_byte%0d got %0h want %0h", name, i, i < rx.size() ? rx[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (b2b != 0) begin failures++; $display("FAIL %s_b2b got %0d want 0", name, b2b); end
    endtask
    task automatic test_digits();
        test_line("digit_09", 8'h09, 8'h30, 8'h39);
        test_line("digit_f0", 8'hF0, 8'h46, 8'h30);
    endtask
    task automatic test_backpressure();
        int stall_bad = 0;
        logic [7:0] exp[4];
        bit to;
`ifdef PB_READ_HEX_EN
        exp = '{8'h41, 8'h35, 8'h0D, 8'h0A};
`else
        exp = '{8'hA5, 8'h00, 8'h00, 8'h00};
`endif
        bus.pb_data_in = 8'hA5;
        bus.tx_fifo_full = 1'b1;
        rx.delete();
        b2b = 0;
        issue(3'd1, 1'b1);
        repeat (16) @(negedge clock);
        repeat (20) begin
            @(negedge clock);
            if (bus.tx_fifo_write_en || !bus.busy) stall_bad++;
        end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall got %0d bad cycles want 0", stall_bad); end
        checks++; if (rx.size() != 0) begin failures++; $display("FAIL bp_no_write got %0d writes want 0", rx.size()); end
        bus.tx_fifo_full = 1'b0;
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL bp_idle got timeout want idle"); end
        checks++; if (rx.size() != LEN) begin failures++; $display("FAIL bp_len got %0d want %0d", rx.size(), LEN); end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp[i]) begin
                failures++; $display("FAIL bp_byte%0d got %0h want %0h", i, i < rx.size() ? rx[i] : 8'hxx, exp[i]);
            end
        end
    endtask
    task automatic test_busy_req();
        logic [7:0] exp[4];
        bit to;
`ifdef PB_READ_HEX_EN
        exp = '{8'h33, 8'h43, 8'h0D, 8'h0A};
`else
        exp = '{8'h3C, 8'h00, 8'h00, 8'h00};
`endif
        bus.pb_data_in = 8'h3C;
        rx.delete();
        issue(3'd2, 1'b0);
        repeat (5) @(negedge clock);
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got %b want 0", bus.req_ready); end
        bus.req_valid = 1'b1;
        bus.req_addr = 3'd5;
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (bus.pb_addr !== 3'd2) begin failures++; $display("FAIL busy_addr got %0d want 2", bus.pb_addr); end
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL busy_idle got timeout want idle"); end
        repeat (30) @(negedge clock);
        checks++; if (rx.size() != LEN) begin failures++; $display("FAIL busy_len got %0d want %0d", rx.size(), LEN); end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp[i]) begin
                failures++; $display("FAIL busy_byte%0d got %0h want %0h", i, i < rx.size() ? rx[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL busy_no_queue got ready=%b want 1", bus.req_ready); end
    endtask
    task automatic test_reset_mid();
        bus.pb_data_in = 8'h77;
        rx.delete();
        issue(3'd6, 1'b0);
        repeat (8) @(negedge clock);
        checks++; if (bus.pb_rd !== 1'b1) begin failures++; $display("FAIL rst_pre_rd got %b want 1", bus.pb_rd); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.pb_rd !== 1'b0) begin failures++; $display("FAIL rst_rd_drop got %b want 0", bus.pb_rd); end
        checks++; if (bus.pb_addr !== 3'd0 || bus.pb_test_addr !== 1'b1) begin
            failures++; $display("FAIL rst_bus got addr=%0d ta=%b want addr=0 ta=1", bus.pb_addr, bus.pb_test_addr);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        checks++; if (rx.size() != 0) begin failures++; $display("FAIL rst_no_write got %0d writes want 0", rx.size()); end
        checks++; if (bus.req_ready !== 1'b1 || bus.pb_rd !== 1'b0) begin
            failures++; $display("FAIL rst_after got ready=%b rd=%b want ready=1 rd=0", bus.req_ready, bus.pb_rd);
        end
        test_line("rst_fresh", 8'h5A, 8'h35, 8'h41);
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr = 3'd0;
        bus.req_test_addr = 1'b0;
        bus.pb_data_in = 8'h00;
        bus.tx_fifo_full = 1'b0;
        test_reset();
        test_read();
        test_digits();
        test_backpressure();
        test_busy_req();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
